// File: rtl/theta_pkg.sv
// rtl/theta_pkg.sv - shared types and helpers for the theta cascade engine
package theta_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CRST  = 3'd2,
    S_RUN   = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic int ndim_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic longint angle_pi(input int aw);
    return longint'(1) << (aw - 1);
  endfunction

  function automatic int elem_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/theta_cascade_engine.sv
// rtl/theta_cascade_engine.sv - N-D vector to hyperspherical angles via a shared external CORDIC core
// Optional CORDIC watchdog: define THETA_CORDIC_TIMEOUT_EN.
module theta_cascade_engine
  import theta_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ANGLE_WIDTH    = 16,
  parameter int N_DIM          = 8,
  parameter int NDIM_W         = ndim_width(N_DIM),
  parameter int CORDIC_TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH*N_DIM-1:0]        w_in_flat,
  input  logic [NDIM_W-1:0]                  n_dim_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ANGLE_WIDTH*(N_DIM-1)-1:0]   theta_out,
  output logic [DATA_WIDTH-1:0]              mag_out,
  output logic                               err_out,
  output logic                               busy,
  output logic [DATA_WIDTH-1:0]              cordic_xin,
  output logic [DATA_WIDTH-1:0]              cordic_yin,
  output logic                               cordic_en,
  output logic                               cordic_nrst,
  input  logic [DATA_WIDTH-1:0]              cordic_xout,
  input  logic [ANGLE_WIDTH-1:0]             cordic_angle_out,
  input  logic                               cordic_op_vld
);

  state_t                             r_state, w_next;
  logic [DATA_WIDTH*N_DIM-1:0]        r_w;
  logic [NDIM_W-1:0]                  r_n;
  logic [NDIM_W-1:0]                  r_k;
  logic [DATA_WIDTH-1:0]              r_x_acc;
  logic [ANGLE_WIDTH*(N_DIM-1)-1:0]   r_theta;
  logic [DATA_WIDTH-1:0]              r_mag;
  logic                               r_err;
  logic [DATA_WIDTH-1:0]              w_y;
  logic                               w_bad;
  logic                               w_last;
  logic                               w_core_clr;
  logic                               w_tmo_hit;
  logic                               w_tmo_clr;

  assign w_bad  = (r_n < NDIM_W'(2)) || (r_n > NDIM_W'(N_DIM));
  assign w_last = (r_k + 1'b1) == (r_n - 1'b1);

  // Operand y for step k is element k+1 (w(k+2) in 1-based naming)
  always_comb begin
    w_y = '0;
    for (int j = 1; j < N_DIM; j++) begin
      if (r_k == NDIM_W'(j - 1)) w_y = r_w[elem_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

`ifdef THETA_CORDIC_TIMEOUT_EN
  logic [$clog2(CORDIC_TIMEOUT+1)-1:0] r_tmo_cnt;
  logic                                r_tmo_clr;

  assign w_tmo_hit = (r_state == S_RUN) && !cordic_op_vld &&
                     (r_tmo_cnt == ($clog2(CORDIC_TIMEOUT+1))'(CORDIC_TIMEOUT - 1));
  assign w_tmo_clr = r_tmo_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_tmo_clr <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == S_RUN) ? r_tmo_cnt + 1'b1 : '0;
      r_tmo_clr <= w_tmo_hit;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign w_tmo_clr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_LOAD;
      S_LOAD:  w_next = w_bad ? S_DONE : S_CRST;
      S_CRST:  w_next = S_RUN;
      S_RUN: begin
        if (cordic_op_vld)  w_next = S_STORE;
        else if (w_tmo_hit) w_next = S_DONE;
      end
      S_STORE: w_next = w_last ? S_DONE : S_CRST;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    cordic_en  = 1'b0;
    cordic_xin = '0;
    cordic_yin = '0;
    w_core_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_CRST: begin
        w_core_clr = 1'b1;
        cordic_xin = r_x_acc;
        cordic_yin = w_y;
      end
      S_RUN: begin
        cordic_en  = 1'b1;
        cordic_xin = r_x_acc;
        cordic_yin = w_y;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign cordic_nrst = ~reset & ~w_core_clr & ~w_tmo_clr;

  // Results persist through IDLE and are only cleared by the next LOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w     <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_x_acc <= '0;
      r_theta <= '0;
      r_mag   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_w <= w_in_flat;
            r_n <= n_dim_in;
          end
        end
        S_LOAD: begin
          r_theta <= '0;
          r_mag   <= '0;
          r_err   <= w_bad;
          r_x_acc <= r_w[DATA_WIDTH-1:0];
          r_k     <= '0;
        end
        S_RUN: begin
          if (w_tmo_hit) r_err <= 1'b1;
        end
        S_STORE: begin
          for (int j = 0; j < N_DIM - 1; j++) begin
            if (r_k == NDIM_W'(j)) r_theta[j*ANGLE_WIDTH +: ANGLE_WIDTH] <= cordic_angle_out;
          end
          r_x_acc <= cordic_xout;
          r_k     <= r_k + 1'b1;
          if (w_last) r_mag <= cordic_xout;
        end
        default: ;
      endcase
    end
  end

  assign theta_out = r_theta;
  assign mag_out   = r_mag;
  assign err_out   = r_err;

endmodule

// File: tb/tb_theta_cascade_engine.sv
// tb/tb_theta_cascade_engine.sv - directed self-checking bench with a behavioural CORDIC core
module tb_theta_cascade_engine;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int ND = 8;
  localparam int NW = 4;
  localparam real PI = 3.14159265358979;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [DW*ND-1:0]      w_in_flat = '0;
  logic [NW-1:0]         n_dim_in = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [AW*(ND-1)-1:0]  theta_out;
  logic [DW-1:0]         mag_out;
  logic                  err_out;
  logic                  busy;
  logic [DW-1:0]         cordic_xin, cordic_yin;
  logic                  cordic_en, cordic_nrst;
  logic [DW-1:0]         cordic_xout = '0;
  logic [AW-1:0]         cordic_angle_out = '0;
  logic                  cordic_op_vld = 1'b0;

  int total = 0;
  int bad = 0;
  int vec [ND];
  int lat = 3;
  bit hang = 1'b0;
  int m_cnt = 0;
  int nrst_pulses = 0;
  int en_cycles = 0;

  theta_cascade_engine dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .w_in_flat(w_in_flat), .n_dim_in(n_dim_in), .out_valid(out_valid),
    .out_ready(out_ready), .theta_out(theta_out), .mag_out(mag_out),
    .err_out(err_out), .busy(busy), .cordic_xin(cordic_xin), .cordic_yin(cordic_yin),
    .cordic_en(cordic_en), .cordic_nrst(cordic_nrst), .cordic_xout(cordic_xout),
    .cordic_angle_out(cordic_angle_out), .cordic_op_vld(cordic_op_vld)
  );

  always #5 clk = ~clk;

  function automatic int m_ang(input int x, input int y);
    return int'($atan2(real'(y), real'(x)) * 32768.0 / PI);
  endfunction

  function automatic int m_mag(input int x, input int y);
    return int'($sqrt(real'(x * x + y * y)));
  endfunction

  always @(posedge clk) begin
    if (!cordic_nrst || !cordic_en) begin
      m_cnt <= 0;
      cordic_op_vld <= 1'b0;
    end else if (!hang) begin
      if (m_cnt == lat - 1) begin
        cordic_op_vld    <= 1'b1;
        cordic_angle_out <= AW'(m_ang(int'($signed(cordic_xin)), int'($signed(cordic_yin))));
        cordic_xout      <= DW'(m_mag(int'($signed(cordic_xin)), int'($signed(cordic_yin))));
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && !cordic_nrst) nrst_pulses = nrst_pulses + 1;
    if (cordic_en) en_cycles = en_cycles + 1;
  end

  function automatic int slot(input int j);
    logic [AW-1:0] s;
    s = theta_out[j*AW +: AW];
    return int'($signed(s));
  endfunction

  task automatic load_vec(input int n);
    for (int k = 0; k < ND; k++) w_in_flat[k*DW +: DW] = DW'(vec[k]);
    n_dim_in = NW'(n);
  endtask

  task automatic start_vec(input int n);
    @(negedge clk);
    load_vec(n);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL wait_out: out_valid=%0b after %0d cycles, required 1", out_valid, cyc);
    end
  endtask

  task automatic ack;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%0b busy=%0b out_valid=%0b required 1 0 0", in_ready, busy, out_valid);
    end
    total++;
    if (cordic_en !== 1'b0 || cordic_nrst !== 1'b0 || cordic_xin !== '0 || cordic_yin !== '0) begin
      bad++;
      $display("FAIL reset_core: en=%0b nrst=%0b xin=%0h yin=%0h required 0 0 0 0", cordic_en, cordic_nrst, cordic_xin, cordic_yin);
    end
    total++;
    if (theta_out !== '0 || mag_out !== '0 || err_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: theta=%0h mag=%0h err=%0b required 0", theta_out, mag_out, err_out);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (cordic_nrst !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_nrst: got %0b required 1", cordic_nrst);
    end
  endtask

  task automatic test_n7;
    int cyc;
    int exp_th [6];
    exp_th = '{8192, 9964, 0, 2100, 2059, 3898};
    vec = '{1000, 1000, 2000, 0, 500, 500, 1000, 0};
    nrst_pulses = 0;
    start_vec(7);
    wait_out(cyc);
    for (int j = 0; j < 6; j++) begin
      total++;
      if (slot(j) > exp_th[j] + 16 || slot(j) < exp_th[j] - 16) begin
        bad++;
        $display("FAIL n7_theta%0d: got %0d required %0d+-16", j + 1, slot(j), exp_th[j]);
      end
    end
    total++;
    if (slot(6) !== 0) begin
      bad++;
      $display("FAIL n7_theta7: got %0d required 0", slot(6));
    end
    total++;
    if (int'(mag_out) > 2742 || int'(mag_out) < 2736) begin
      bad++;
      $display("FAIL n7_mag: got %0d required 2739+-3", mag_out);
    end
    total++;
    if (err_out !== 1'b0) begin
      bad++;
      $display("FAIL n7_err: got %0b required 0", err_out);
    end
    total++;
    if (nrst_pulses != 6) begin
      bad++;
      $display("FAIL n7_nrst_pulses: got %0d required 6", nrst_pulses);
    end
    ack;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL n7_return_idle: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_n2;
    int cyc;
    vec = '{0, 1000, 0, 0, 0, 0, 0, 0};
    start_vec(2);
    wait_out(cyc);
    total++;
    if (slot(0) > 16400 || slot(0) < 16368) begin
      bad++;
      $display("FAIL n2_theta1: got %0d required 16384+-16", slot(0));
    end
    total++;
    if (int'(mag_out) > 1003 || int'(mag_out) < 997) begin
      bad++;
      $display("FAIL n2_mag: got %0d required 1000+-3", mag_out);
    end
    total++;
    if (theta_out[AW*(ND-1)-1:AW] !== '0) begin
      bad++;
      $display("FAIL n2_upper_slots: got %0h required 0", theta_out[AW*(ND-1)-1:AW]);
    end
    ack;
  endtask

  task automatic test_bad_n;
    int cyc;
    int ns [2];
    ns = '{0, ND + 1};
    vec = '{100, 200, 300, 400, 500, 600, 700, 800};
    for (int i = 0; i < 2; i++) begin
      en_cycles = 0;
      start_vec(ns[i]);
      cyc = 0;
      while (!out_valid && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      total++;
      if (!out_valid || cyc > 3) begin
        bad++;
        $display("FAIL badn%0d_latency: out_valid=%0b after %0d cycles required within 3", ns[i], out_valid, cyc);
      end
      total++;
      if (err_out !== 1'b1 || mag_out !== '0 || theta_out !== '0) begin
        bad++;
        $display("FAIL badn%0d_out: err=%0b mag=%0d theta=%0h required 1 0 0", ns[i], err_out, mag_out, theta_out);
      end
      total++;
      if (en_cycles != 0) begin
        bad++;
        $display("FAIL badn%0d_cordic_en: got %0d enable cycles required 0", ns[i], en_cycles);
      end
      ack;
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit stable_ok, ready_ok;
    logic [AW*(ND-1)-1:0] th_s;
    logic [DW-1:0] mag_s;
    vec = '{600, 800, 0, 0, 0, 0, 0, 0};
    start_vec(2);
    wait_out(cyc);
    total++;
    if (slot(0) > 9688 || slot(0) < 9656 || int'(mag_out) > 1003 || int'(mag_out) < 997) begin
      bad++;
      $display("FAIL b2b_first: theta1=%0d mag=%0d required 9672+-16 1000+-3", slot(0), mag_out);
    end
    th_s = theta_out;
    mag_s = mag_out;
    vec = '{800, 600, 0, 0, 0, 0, 0, 0};
    load_vec(2);
    in_valid = 1'b1;
    stable_ok = 1'b1;
    ready_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (theta_out !== th_s || mag_out !== mag_s || err_out !== 1'b0 || out_valid !== 1'b1) stable_ok = 1'b0;
      if (in_ready !== 1'b0) ready_ok = 1'b0;
    end
    total++;
    if (!stable_ok) begin
      bad++;
      $display("FAIL stall_stable: theta=%0h mag=%0d out_valid=%0b required hold %0h %0d 1", theta_out, mag_out, out_valid, th_s, mag_s);
    end
    total++;
    if (!ready_ok) begin
      bad++;
      $display("FAIL stall_in_ready: in_ready=%0b required 0 throughout", in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || mag_out !== mag_s) begin
      bad++;
      $display("FAIL idle_retain: in_ready=%0b mag=%0d required 1 %0d", in_ready, mag_out, mag_s);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(cyc);
    total++;
    if (slot(0) > 6728 || slot(0) < 6696 || int'(mag_out) > 1003 || int'(mag_out) < 997) begin
      bad++;
      $display("FAIL b2b_second: theta1=%0d mag=%0d required 6712+-16 1000+-3", slot(0), mag_out);
    end
    ack;
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    vec = '{1000, 1000, 1000, 0, 0, 0, 0, 0};
    start_vec(3);
    cyc = 0;
    while ((theta_out == '0 || !cordic_en) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (theta_out == '0 || !cordic_en) begin
      bad++;
      $display("FAIL midrun_reach: theta=%0h en=%0b required second step running", theta_out, cordic_en);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || cordic_en !== 1'b0 || cordic_nrst !== 1'b0) begin
      bad++;
      $display("FAIL midrun_ctrl: in_ready=%0b busy=%0b out_valid=%0b en=%0b nrst=%0b required 1 0 0 0 0", in_ready, busy, out_valid, cordic_en, cordic_nrst);
    end
    total++;
    if (theta_out !== '0 || mag_out !== '0 || err_out !== 1'b0 || cordic_xin !== '0) begin
      bad++;
      $display("FAIL midrun_data: theta=%0h mag=%0d err=%0b xin=%0h required 0", theta_out, mag_out, err_out, cordic_xin);
    end
    @(negedge clk);
    reset = 1'b0;
    vec = '{300, 400, 0, 0, 0, 0, 0, 0};
    start_vec(2);
    wait_out(cyc);
    total++;
    if (slot(0) > 9688 || slot(0) < 9656 || int'(mag_out) > 503 || int'(mag_out) < 497 || err_out !== 1'b0) begin
      bad++;
      $display("FAIL midrun_recover: theta1=%0d mag=%0d err=%0b required 9672+-16 500+-3 0", slot(0), mag_out, err_out);
    end
    ack;
  endtask

`ifdef THETA_CORDIC_TIMEOUT_EN
  task automatic test_timeout;
    int cyc;
    hang = 1'b1;
    en_cycles = 0;
    nrst_pulses = 0;
    vec = '{1000, 1000, 1000, 0, 0, 0, 0, 0};
    start_vec(3);
    wait_out(cyc);
    @(negedge clk);
    total++;
    if (err_out !== 1'b1 || mag_out !== '0 || theta_out !== '0) begin
      bad++;
      $display("FAIL tmo_out: err=%0b mag=%0d theta=%0h required 1 0 0", err_out, mag_out, theta_out);
    end
    total++;
    if (en_cycles != 64) begin
      bad++;
      $display("FAIL tmo_run_cycles: got %0d required 64", en_cycles);
    end
    total++;
    if (nrst_pulses != 2) begin
      bad++;
      $display("FAIL tmo_nrst_pulses: got %0d required 2", nrst_pulses);
    end
    hang = 1'b0;
    ack;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL tmo_idle: in_ready=%0b required 1", in_ready);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_n7;
    test_n2;
    test_bad_n;
    test_back_to_back;
    test_reset_mid_run;
`ifdef THETA_CORDIC_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/theta_cascade_engine.md
Name: theta_cascade_engine

Overview:
- Parametrised successor to the sequential CORDIC theta processor.
- Converts an N-dimensional vector into N-1 hyperspherical angles plus the final magnitude, reusing one external CORDIC vectoring core.
- Adds over the previous generation: runtime dimension count, valid/ready handshakes on both sides, an error flag, and magnitude output.
- Sits between the FastICA weight-update stage and the rotation/simplex stages.

Parameters:
- DATA_WIDTH, 16: element and magnitude width, signed.
- ANGLE_WIDTH, 16: angle width, signed; +π maps to 2^(ANGLE_WIDTH-1).
- N_DIM, 8: maximum vector dimension supported.
- NDIM_W, $clog2(N_DIM+1): width of n_dim_in.
- CORDIC_TIMEOUT, 64: watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  high only in IDLE.
- w_in_flat  in  DATA_WIDTH*N_DIM  element k at bits [(k+1)*DW-1 -: DW], k=0 is w1.
- n_dim_in  in  NDIM_W  active dimension count.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accept.
- theta_out  out  ANGLE_WIDTH*(N_DIM-1)  slot j is θ(j+1).
- mag_out  out  DATA_WIDTH  final cascade magnitude.
- err_out  out  1  request rejected or aborted.
- busy  out  1  state != IDLE.
- cordic_xin, cordic_yin  out  DATA_WIDTH each  core operands.
- cordic_en  out  1  core enable.
- cordic_nrst  out  1  active-low core clear.
- cordic_xout  in  DATA_WIDTH  gain-compensated magnitude from core.
- cordic_angle_out  in  ANGLE_WIDTH  angle from core.
- cordic_op_vld  in  1  core result valid.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all registers cleared.
  - Outputs: in_ready=1, out_valid=0, theta_out=0, mag_out=0, err_out=0, busy=0, cordic_en=0, cordic_xin/yin=0.
  - cordic_nrst=0 while reset is high.
- States: IDLE, LOAD, CRST, RUN, STORE, DONE.
- IDLE: in_valid&&in_ready captures w_in_flat and n_dim_in, then goes to LOAD.
- LOAD:
  - Clear all theta slots.
  - n<2 or n>N_DIM: err=1, mag=0, go to DONE; no CORDIC activity.
  - Otherwise: x_acc=w1, k=0, go to CRST.
- CRST (one cycle):
  - cordic_nrst=0.
  - cordic_xin=x_acc, cordic_yin=w(k+2).
  - Go to RUN.
- RUN:
  - cordic_nrst=1, cordic_en=1; operands held stable.
  - Wait for cordic_op_vld, then go to STORE.
  - op_vld seen in the same cycle RUN is entered counts.
- STORE:
  - theta[k]=cordic_angle_out; x_acc=cordic_xout; k=k+1.
  - If k==n-1: mag=x_acc, go to DONE. Else go to CRST.
- DONE:
  - out_valid=1.
  - theta_out, mag_out, err_out stable while out_valid=1 and out_ready=0.
  - out_ready returns to IDLE next cycle; outputs retain values until the next LOAD.
- Slots j≥n-1 read 0.
- Latency from accept to out_valid: 2 + (n-1)*(L+2) cycles, where L is the core latency from en to op_vld.
- Start while busy: not accepted (in_ready=0). in_valid in DONE is ignored; the new vector is accepted in IDLE.
- No saturation: caller guarantees vector norm < 2^(DATA_WIDTH-1).
- Reset mid-operation aborts immediately; there is no partial output.

Optional Feature:
- THETA_CORDIC_TIMEOUT_EN defined:
  - A counter runs in RUN.
  - If CORDIC_TIMEOUT cycles pass without op_vld: err=1, the completed slots are kept, mag=0, cordic_nrst is pulsed low one cycle, then DONE.
- Undefined: no counter; RUN waits indefinitely.

Decomposition:
- Package theta_pkg holds:
  - state enum encoding;
  - NDIM_W function;
  - angle constant ANGLE_PI=2^(AW-1);
  - slice helper for element k.
- No sub-module is needed; the watchdog is an ifdef'd always block in the top.

Test Plan:
- n=7, w={1000,1000,2000,0,500,500,1000} (w1 first). Expected, ±16 LSB angle and ±3 LSB magnitude:
  - θ1..θ6 ≈ 8192, 9964, 0, 2100, 2059, 3898;
  - mag ≈ 2739;
  - err=0; exactly 6 cordic_nrst pulses.
- n=2, w1=0, w2=1000 → θ1 ≈ 16384, mag ≈ 1000, other slots 0.
- n=0 and n=N_DIM+1 → out_valid within 3 cycles, err=1, cordic_en never asserted.
- out_ready held low 20 cycles after out_valid → outputs stable, in_ready=0, second in_valid ignored until IDLE.
- Reset asserted mid-RUN → all outputs at reset values the same cycle, cordic_nrst=0; next vector completes correctly.
- THETA_CORDIC_TIMEOUT_EN with a core that never asserts op_vld → err=1 after 64 RUN cycles, mag=0, return to IDLE after out_ready.
